// File: rtl/pe_act_sched.sv
// Per-PE activation scheduler: buffers input activations and issues one compute beat per owned output activation.
// Optional build macro PE_ZERO_SKIP_EN drops zero-valued activations at the FIFO input.
module pe_act_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 8,
   parameter int LAYER_W    = 4,
   parameter int ACT_NO_W   = 4,
   parameter int WMEM_W     = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic [LAYER_W-1:0]       cfg_layer_idx,
   input  logic [ADDR_W-1:0]        cfg_col_dim,
   input  logic [WMEM_W-1:0]        cfg_w_mem_offset,
   input  logic [ACT_NO_W:0]        cfg_num_out,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_act_idx_i,
   input  logic signed [DATA_W-1:0] in_act_value_i,
   input  logic                     in_last,
   input  logic                     stall,
   output logic                     comp_en,
   output logic [LAYER_W-1:0]       layer_idx,
   output logic [ADDR_W-1:0]        in_act_idx,
   output logic signed [DATA_W-1:0] in_act_value,
   output logic [ACT_NO_W-1:0]      out_act_addr,
   output logic [ADDR_W-1:0]        col_dim,
   output logic [WMEM_W-1:0]        w_mem_offset,
   output logic                     busy,
   output logic                     layer_done
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [PW:0]              wr_ptr_q, wr_ptr_d;
   logic [PW:0]              rd_ptr_q, rd_ptr_d;
   logic                     last_seen_q, last_seen_d;
   logic [ACT_NO_W-1:0]      out_cnt_q, out_cnt_d;
   logic [ACT_NO_W:0]        num_out_q, num_out_d;
   logic [LAYER_W-1:0]       layer_q, layer_d;
   logic [ADDR_W-1:0]        col_q, col_d;
   logic [WMEM_W-1:0]        woff_q, woff_d;
   logic                     comp_en_q, comp_en_d;
   logic [ADDR_W-1:0]        idx_q, idx_d;
   logic signed [DATA_W-1:0] val_q, val_d;
   logic [ACT_NO_W-1:0]      addr_q, addr_d;
   logic                     done_q, done_d;

   logic [ADDR_W-1:0]        idx_mem_q [FIFO_DEPTH];
   logic signed [DATA_W-1:0] val_mem_q [FIFO_DEPTH];

   logic full, empty, push, fifo_wr, issue, last_beat, pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign in_ready  = (state_q == RUN) && !full;
   assign push      = in_valid && in_ready;
`ifdef PE_ZERO_SKIP_EN
   assign fifo_wr   = push && (in_act_value_i != '0);
`else
   assign fifo_wr   = push;
`endif
   assign issue     = (state_q == RUN) && !empty && !stall;
   assign last_beat = ({1'b0, out_cnt_q} == (num_out_q - 1'b1));
   assign pop       = issue && ((num_out_q == '0) || last_beat);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      last_seen_d = last_seen_q;
      out_cnt_d   = out_cnt_q;
      num_out_d   = num_out_q;
      layer_d     = layer_q;
      col_d       = col_q;
      woff_d      = woff_q;
      comp_en_d   = 1'b0;
      idx_d       = idx_q;
      val_d       = val_q;
      addr_d      = addr_q;
      done_d      = 1'b0;

      if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d     = RUN;
               layer_d     = cfg_layer_idx;
               col_d       = cfg_col_dim;
               woff_d      = cfg_w_mem_offset;
               num_out_d   = cfg_num_out;
               last_seen_d = 1'b0;
               out_cnt_d   = '0;
            end
         end
         RUN: begin
            if (push && in_last) last_seen_d = 1'b1;
            if (issue && (num_out_q != '0)) begin
               comp_en_d = 1'b1;
               idx_d     = idx_mem_q[rd_ptr_q[PW-1:0]];
               val_d     = val_mem_q[rd_ptr_q[PW-1:0]];
               addr_d    = out_cnt_q;
               out_cnt_d = last_beat ? '0 : out_cnt_q + 1'b1;
            end
            // An empty FIFO means the final pop has already retired.
            if (last_seen_q && empty) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         last_seen_q <= 1'b0;
         out_cnt_q   <= '0;
         num_out_q   <= '0;
         layer_q     <= '0;
         col_q       <= '0;
         woff_q      <= '0;
         comp_en_q   <= 1'b0;
         idx_q       <= '0;
         val_q       <= '0;
         addr_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         last_seen_q <= last_seen_d;
         out_cnt_q   <= out_cnt_d;
         num_out_q   <= num_out_d;
         layer_q     <= layer_d;
         col_q       <= col_d;
         woff_q      <= woff_d;
         comp_en_q   <= comp_en_d;
         idx_q       <= idx_d;
         val_q       <= val_d;
         addr_q      <= addr_d;
         done_q      <= done_d;
      end
   end

   // Storage needs no reset: pointer reset discards any buffered entries.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         idx_mem_q[wr_ptr_q[PW-1:0]] <= in_act_idx_i;
         val_mem_q[wr_ptr_q[PW-1:0]] <= in_act_value_i;
      end
   end

   assign comp_en      = comp_en_q;
   assign layer_idx    = layer_q;
   assign in_act_idx   = idx_q;
   assign in_act_value = val_q;
   assign out_act_addr = addr_q;
   assign col_dim      = col_q;
   assign w_mem_offset = woff_q;
   assign busy         = (state_q != IDLE);
   assign layer_done   = done_q;

endmodule

// File: tb/tb_pe_act_sched.sv
// Directed-vector bench for pe_act_sched; expectations are hand-derived cycle counts and beat sequences.
module tb_pe_act_sched;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_start = 1'b0;
   logic [3:0]        cfg_layer_idx = '0;
   logic [7:0]        cfg_col_dim = '0;
   logic [11:0]       cfg_w_mem_offset = '0;
   logic [4:0]        cfg_num_out = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [7:0]        in_act_idx_i = '0;
   logic signed [15:0] in_act_value_i = '0;
   logic              in_last = 1'b0;
   logic              stall = 1'b0;
   logic              comp_en;
   logic [3:0]        layer_idx;
   logic [7:0]        in_act_idx;
   logic signed [15:0] in_act_value;
   logic [3:0]        out_act_addr;
   logic [7:0]        col_dim;
   logic [11:0]       w_mem_offset;
   logic              busy;
   logic              layer_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int p_cyc = 0;
   int   b_cyc[$];
   logic [7:0]  b_idx[$];
   logic [15:0] b_val[$];
   logic [3:0]  b_addr[$];

   pe_act_sched #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_layer_idx(cfg_layer_idx),
      .cfg_col_dim(cfg_col_dim), .cfg_w_mem_offset(cfg_w_mem_offset), .cfg_num_out(cfg_num_out),
      .in_valid(in_valid), .in_ready(in_ready), .in_act_idx_i(in_act_idx_i),
      .in_act_value_i(in_act_value_i), .in_last(in_last), .stall(stall), .comp_en(comp_en),
      .layer_idx(layer_idx), .in_act_idx(in_act_idx), .in_act_value(in_act_value),
      .out_act_addr(out_act_addr), .col_dim(col_dim), .w_mem_offset(w_mem_offset),
      .busy(busy), .layer_done(layer_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (comp_en) begin
         b_cyc.push_back(cyc);
         b_idx.push_back(in_act_idx);
         b_val.push_back(in_act_value);
         b_addr.push_back(out_act_addr);
      end
      if (layer_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      b_cyc.delete(); b_idx.delete(); b_val.delete(); b_addr.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; cfg_start = 1'b0; stall = 1'b0; in_last = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic start_layer(input logic [3:0] l, input logic [7:0] c, input logic [11:0] w,
                              input logic [4:0] n);
      cfg_layer_idx = l; cfg_col_dim = c; cfg_w_mem_offset = w; cfg_num_out = n;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   // Leaves p_cyc at the edge number that accepted the push.
   task automatic push_act(input logic [7:0] idx, input logic [15:0] val, input logic last);
      int n;
      in_valid = 1'b1; in_act_idx_i = idx; in_act_value_i = val; in_last = last;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL push_timeout in_ready got %b need 1", in_ready);
      end
      tick();
      p_cyc = cyc;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({comp_en, in_ready, busy, layer_done} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl got %b need 0000", {comp_en, in_ready, busy, layer_done});
      end
      checks++;
      if ({layer_idx, in_act_idx, in_act_value, out_act_addr, col_dim, w_mem_offset} !== 52'd0) begin
         errors++; $display("FAIL reset_data got %h need 0",
            {layer_idx, in_act_idx, in_act_value, out_act_addr, col_dim, w_mem_offset});
      end
   endtask

   task automatic test_basic();
      do_reset();
      start_layer(4'd3, 8'h21, 12'h345, 5'd3);
      checks++;
      if ({busy, in_ready} !== 2'b11) begin
         errors++; $display("FAIL basic_run got %b need 11", {busy, in_ready});
      end
      checks++;
      if ({layer_idx, col_dim, w_mem_offset} !== {4'd3, 8'h21, 12'h345}) begin
         errors++; $display("FAIL basic_cfg got %h need %h", {layer_idx, col_dim, w_mem_offset},
                            {4'd3, 8'h21, 12'h345});
      end
      clear_mon();
      push_act(8'd5, 16'h0012, 1'b0);
      checks++;
      if (comp_en !== 1'b0) begin
         errors++; $display("FAIL basic_early got %b need 0", comp_en);
      end
      cfg_layer_idx = 4'd9; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      repeat (5) tick();
      checks++;
      if (layer_idx !== 4'd3) begin
         errors++; $display("FAIL basic_start_ignored got %0d need 3", layer_idx);
      end
      checks++;
      if (b_cyc.size() !== 3) begin
         errors++; $display("FAIL basic_count got %0d need 3", b_cyc.size());
      end
      for (int i = 0; i < b_cyc.size(); i++) begin
         checks++;
         if ({b_cyc[i], b_idx[i], b_val[i], b_addr[i]} !== {p_cyc + 1 + i, 8'd5, 16'h0012, 4'(i)}) begin
            errors++; $display("FAIL basic_beat%0d got cyc %0d idx %0d val %h addr %0d need cyc %0d idx 5 val 0012 addr %0d",
                               i, b_cyc[i], b_idx[i], b_val[i], b_addr[i], p_cyc + 1 + i, i);
         end
      end
   endtask

   task automatic test_back_pressure();
      int first;
      do_reset();
      start_layer(4'd1, 8'h10, 12'h100, 5'd4);
      clear_mon();
      push_act(8'd10, 16'h0020, 1'b0);
      first = p_cyc;
      for (int i = 1; i < 4; i++) push_act(8'(10 + i), 16'(32 + i), 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_full_ready got %b need 0", in_ready);
      end
      for (int i = 4; i < 6; i++) push_act(8'(10 + i), 16'(32 + i), 1'b0);
      repeat (30) tick();
      checks++;
      if (b_cyc.size() !== 24) begin
         errors++; $display("FAIL bp_count got %0d need 24", b_cyc.size());
      end
      for (int k = 0; k < b_cyc.size(); k++) begin
         checks++;
         if ({b_cyc[k], b_idx[k], b_val[k], b_addr[k]} !==
             {first + 1 + k, 8'(10 + k / 4), 16'(32 + k / 4), 4'(k % 4)}) begin
            errors++; $display("FAIL bp_beat%0d got cyc %0d idx %0d val %h addr %0d need cyc %0d idx %0d addr %0d",
                               k, b_cyc[k], b_idx[k], b_val[k], b_addr[k], first + 1 + k, 10 + k / 4, k % 4);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      start_layer(4'd2, 8'h05, 12'h010, 5'd4);
      clear_mon();
      push_act(8'd7, 16'h0033, 1'b0);
      tick(); tick();
      checks++;
      if ({comp_en, out_act_addr} !== {1'b1, 4'd1}) begin
         errors++; $display("FAIL stall_pre got en %b addr %0d need en 1 addr 1", comp_en, out_act_addr);
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({comp_en, out_act_addr, in_act_idx} !== {1'b0, 4'd1, 8'd7}) begin
            errors++; $display("FAIL stall_hold%0d got en %b addr %0d idx %0d need en 0 addr 1 idx 7",
                               i, comp_en, out_act_addr, in_act_idx);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({comp_en, out_act_addr} !== {1'b1, 4'd2}) begin
         errors++; $display("FAIL stall_resume got en %b addr %0d need en 1 addr 2", comp_en, out_act_addr);
      end
      tick(); tick();
      checks++;
      if (b_cyc.size() !== 4) begin
         errors++; $display("FAIL stall_count got %0d need 4", b_cyc.size());
      end
      for (int i = 0; i < b_cyc.size(); i++) begin
         checks++;
         if (b_addr[i] !== 4'(i)) begin
            errors++; $display("FAIL stall_seq%0d got addr %0d need %0d", i, b_addr[i], i);
         end
      end
   endtask

   task automatic test_completion();
      do_reset();
      start_layer(4'd2, 8'h08, 12'h020, 5'd2);
      clear_mon();
      push_act(8'd1, 16'h0041, 1'b0);
      push_act(8'd2, 16'h0042, 1'b0);
      push_act(8'd3, 16'h0043, 1'b1);
      repeat (12) tick();
      checks++;
      if (b_cyc.size() !== 6) begin
         errors++; $display("FAIL done_count got %0d need 6", b_cyc.size());
      end
      for (int i = 0; i < b_cyc.size(); i++) begin
         checks++;
         if ({b_idx[i], b_addr[i], b_cyc[i]} !== {8'(1 + i / 2), 4'(i % 2), b_cyc[0] + i}) begin
            errors++; $display("FAIL done_beat%0d got idx %0d addr %0d cyc %0d need idx %0d addr %0d cyc %0d",
                               i, b_idx[i], b_addr[i], b_cyc[i], 1 + i / 2, i % 2, b_cyc[0] + i);
         end
      end
      checks++;
      if (b_cyc.size() == 6 && (done_cnt !== 1 || done_cyc !== b_cyc[5] + 2)) begin
         errors++; $display("FAIL done_pulse got cnt %0d cyc %0d need cnt 1 cyc %0d", done_cnt, done_cyc, b_cyc[5] + 2);
      end
      checks++;
      if ({busy, in_ready} !== 2'b00) begin
         errors++; $display("FAIL done_idle got %b need 00", {busy, in_ready});
      end
      start_layer(4'd2, 8'h08, 12'h020, 5'd0);
      clear_mon();
      push_act(8'd1, 16'h0005, 1'b0);
      push_act(8'd2, 16'h0006, 1'b1);
      repeat (8) tick();
      checks++;
      if ({b_cyc.size(), done_cnt, 31'd0, busy} !== {32'd0, 32'd1, 31'd0, 1'b0}) begin
         errors++; $display("FAIL num0 got beats %0d done %0d busy %b need beats 0 done 1 busy 0",
                            b_cyc.size(), done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_layer(4'd5, 8'h33, 12'h0AB, 5'd4);
      clear_mon();
      push_act(8'd20, 16'h0061, 1'b0);
      push_act(8'd21, 16'h0062, 1'b0);
      push_act(8'd22, 16'h0063, 1'b0);
      checks++;
      if ({comp_en, in_act_idx} !== {1'b1, 8'd20}) begin
         errors++; $display("FAIL rmid_active got en %b idx %0d need en 1 idx 20", comp_en, in_act_idx);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({comp_en, in_ready, busy, layer_done} !== 4'b0000) begin
         errors++; $display("FAIL rmid_ctrl got %b need 0000", {comp_en, in_ready, busy, layer_done});
      end
      checks++;
      if ({layer_idx, in_act_idx, in_act_value, out_act_addr, col_dim, w_mem_offset} !== 52'd0) begin
         errors++; $display("FAIL rmid_data got %h need 0",
            {layer_idx, in_act_idx, in_act_value, out_act_addr, col_dim, w_mem_offset});
      end
      start_layer(4'd6, 8'h44, 12'h0CD, 5'd1);
      clear_mon();
      push_act(8'd9, 16'h0055, 1'b1);
      repeat (6) tick();
      checks++;
      if (b_cyc.size() !== 1) begin
         errors++; $display("FAIL rmid_count got %0d need 1", b_cyc.size());
      end else begin
         checks++;
         if ({b_idx[0], b_val[0], b_addr[0], layer_idx} !== {8'd9, 16'h0055, 4'd0, 4'd6}) begin
            errors++; $display("FAIL rmid_beat got idx %0d val %h addr %0d layer %0d need 9 0055 0 6",
                               b_idx[0], b_val[0], b_addr[0], layer_idx);
         end
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++; $display("FAIL rmid_done got %0d need 1", done_cnt);
      end
   endtask

   task automatic test_zero_skip();
      do_reset();
      start_layer(4'd7, 8'h02, 12'h003, 5'd1);
      clear_mon();
      push_act(8'd1, 16'h0000, 1'b0);
      push_act(8'd2, 16'h0007, 1'b0);
      push_act(8'd3, 16'h0000, 1'b1);
      repeat (8) tick();
`ifdef PE_ZERO_SKIP_EN
      checks++;
      if (b_cyc.size() !== 1) begin
         errors++; $display("FAIL zskip_count got %0d need 1", b_cyc.size());
      end else begin
         checks++;
         if ({b_idx[0], b_val[0]} !== {8'd2, 16'h0007}) begin
            errors++; $display("FAIL zskip_beat got idx %0d val %h need 2 0007", b_idx[0], b_val[0]);
         end
      end
`else
      checks++;
      if (b_cyc.size() !== 3) begin
         errors++; $display("FAIL zkeep_count got %0d need 3", b_cyc.size());
      end else begin
         checks++;
         if ({b_val[0], b_val[1], b_val[2], b_idx[2]} !== {16'h0000, 16'h0007, 16'h0000, 8'd3}) begin
            errors++; $display("FAIL zkeep_vals got %h %h %h idx %0d need 0000 0007 0000 3",
                               b_val[0], b_val[1], b_val[2], b_idx[2]);
         end
      end
`endif
      checks++;
      if ({done_cnt, 31'd0, busy} !== {32'd1, 31'd0, 1'b0}) begin
         errors++; $display("FAIL zero_done got done %0d busy %b need 1 0", done_cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_pressure();
      test_stall();
      test_completion();
      test_reset_mid();
      test_zero_skip();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pe_act_sched.md
# pe_act_sched

Per-PE activation scheduler that sequences the weight-address/memory stage. Buffers incoming input activations (index, value) in a small FIFO. For each buffered activation, it issues one compute beat per output activation owned by this PE, driving the enable, index, value, layer and weight-offset inputs of the address-computation stage. It also sequences layer start, drain and completion for the PE.

## Interface
Parameters:
- FIFO_DEPTH, 4: input activation FIFO entries; power of two, ≥2.

Ports (widths from pe.vh):
- clk  input  1  system clock; single clock domain.
- rst  input  1  system reset; synchronous, active high.
- cfg_start  input  1  one-cycle layer start pulse; sampled only in IDLE.
- cfg_layer_idx  input  `PeLayerNoBus  layer index; latched on cfg_start.
- cfg_col_dim  input  `PeAddrBus  column dimension; latched on cfg_start.
- cfg_w_mem_offset  input  `WMemAddrBus  weight memory offset; latched on cfg_start.
- cfg_num_out  input  `PeActNoBus+1  output activations owned by this PE, 0..2^`PeActNoBus; latched on cfg_start.
- in_valid  input  1  input activation valid.
- in_ready  output  1  FIFO can accept; equals ~full in RUN, 0 otherwise.
- in_act_idx_i  input  `PeAddrBus  input activation index.
- in_act_value_i  input  `PeDataBus  input activation value.
- in_last  input  1  marks the final activation of the layer; qualified by in_valid & in_ready.
- stall  input  1  downstream hazard; freezes issue.
- comp_en  output  1  compute beat valid.
- layer_idx  output  `PeLayerNoBus  latched layer index.
- in_act_idx  output  `PeAddrBus  index of the activation being issued.
- in_act_value  output  `PeDataBus  value of the activation being issued.
- out_act_addr  output  `PeActNoBus  output activation address of this beat.
- col_dim  output  `PeAddrBus  latched column dimension.
- w_mem_offset  output  `WMemAddrBus  latched weight offset.
- busy  output  1  state ≠ IDLE.
- layer_done  output  1  one-cycle pulse at layer completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on cfg_start. Latch all cfg_*; clear last_seen and out_cnt.
- RUN, push: FIFO push on in_valid & in_ready. If in_last is set on that push, set last_seen.
- RUN, issue: when FIFO not empty and stall=0, register the head onto the outputs with out_act_addr=out_cnt and comp_en=1.
  - out_cnt == cfg_num_out−1: pop head, out_cnt←0.
  - otherwise: out_cnt++.
- cfg_num_out == 0: pop one entry per unstalled cycle with comp_en=0.
- stall=1: comp_en←0. out_cnt and the FIFO hold. Data outputs hold their last value.
- RUN → DONE when last_seen, FIFO empty, and no pop pending. DONE asserts layer_done for one cycle, then → IDLE.
- Simultaneous push and pop are legal, including when the FIFO is full: in_ready reflects the pre-pop full flag, so no push occurs at full.
- cfg_start outside IDLE is ignored.
- in_last arriving with the FIFO empty still completes the layer through DONE.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and LSBs equal. Empty = pointers equal.

## Timing
- Reset values: comp_en=0, in_ready=0, busy=0, layer_done=0. All data outputs (layer_idx, in_act_idx, in_act_value, out_act_addr, col_dim, w_mem_offset) = 0. FIFO empty, state IDLE.
- Reset mid-operation: FIFO contents discarded. Next cycle: all outputs at reset values.
- Latency: activation pushed at cycle t (FIFO previously empty, stall=0) → comp_en=1 at t+2 with out_act_addr=0.
- Throughput: one beat per cycle. An activation occupies cfg_num_out consecutive unstalled cycles.
- Last beat: layer_done pulses 2 cycles after the final comp_en beat (RUN→DONE, DONE→IDLE). busy falls with the IDLE transition.
- in_ready is combinational on state and full only; it has no combinational path from in_valid or stall.

## Configuration
- PE_ZERO_SKIP_EN: when defined, pushes with in_act_value_i == 0 are accepted (in_ready honoured) but not written to the FIFO. An in_last carried by a zero activation still sets last_seen.
- Without the macro, every accepted activation is buffered and issued, zeros included.

## Test plan
- Basic issue: cfg_num_out=3; push (idx=5, val=0x12). Expect comp_en at t+2,t+3,t+4 with out_act_addr 0,1,2, in_act_idx=5, in_act_value=0x12.
- Back-pressure: FIFO_DEPTH=4, cfg_num_out=4, push 6 activations back-to-back. Expect in_ready low after 4 pushes, 24 beats total, order preserved.
- Stall: stall high for 3 cycles mid-activation at out_act_addr=1. Expect comp_en=0 for those cycles, then resume at out_act_addr=2 with no beat lost or duplicated.
- Completion: in_last on third push, cfg_num_out=2. Expect 6 beats, layer_done pulse 2 cycles after the last beat, busy=0 afterward. Also check num_out=0: no comp_en, layer_done still fires.
- Reset mid-layer: assert rst with 3 entries buffered. Expect all outputs zero, in_ready=0. A new cfg_start runs cleanly.
- PE_ZERO_SKIP_EN: push values 0, 7, 0(last). Expect beats only for value 7, then layer_done. Without the macro, beats for all three.
